// File: rtl/accum_bcd_converter_pkg.sv
// Shared calculator definitions: converter state encoding, BCD digit width and
// the helper that sizes the decimal output for a given binary width.
package accum_bcd_converter_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // ceil(width * log10(2)); log10(2) is irrational, so the product is never an
    // integer and the fixed-point approximation rounds the right way.
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/accum_bcd_converter_if.sv
// Input/output handshake bundle between the accumulator and the display stage.
interface accum_bcd_converter_if
    import accum_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic                           in_valid;
    logic                           in_ready;
    logic [WIDTH-1:0]               in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [BCD_W*DIGITS-1:0]        out_bcd;
    logic                           out_neg;
    logic [$clog2(DIGITS+1)-1:0]    out_ndigits;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bcd, out_neg, out_ndigits
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bcd, out_neg, out_ndigits
    );
endinterface

// File: rtl/accum_bcd_converter_dabble_digit.sv
// One BCD digit correction step: digits of 5 or more get +3 before the shift.
module dabble_digit
    import accum_bcd_converter_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
endmodule

// File: rtl/accum_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with an
// optional two's-complement magnitude/sign front end.
module accum_bcd_converter
    import accum_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter bit SIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    accum_bcd_converter_if.slave  bus,
    output logic                  busy
);
    localparam int BW  = BCD_W * DIGITS;
    localparam int NDW = $clog2(DIGITS + 1);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    if (DIGITS < min_digits(WIDTH)) begin : g_digits_too_small
        $error("accum_bcd_converter: DIGITS too small for WIDTH");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [BW-1:0]    out_bcd_q, out_bcd_d;
    logic             out_neg_q, out_neg_d;
    logic [NDW-1:0]   ndig_q, ndig_d;

    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] shifted;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        dabble_digit u_digit (
            .digit_i (bcd_q[gi*BCD_W +: BCD_W]),
            .digit_o (bcd_adj[gi*BCD_W +: BCD_W])
        );
    end

    assign shifted = {bcd_adj, bin_q} << 1;

    function automatic logic [NDW-1:0] sig_digits(input logic [BW-1:0] v);
        logic [NDW-1:0] n;
        n = NDW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*BCD_W +: BCD_W] != '0) n = NDW'(i + 1);
        end
        return n;
    endfunction

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        out_bcd_d = out_bcd_q;
        out_neg_d = out_neg_q;
        ndig_d    = ndig_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    neg_d   = SIGNED & bus.in_data[WIDTH-1];
                    // Magnitude of the most-negative value still fits as unsigned.
                    bin_d   = neg_d ? (~bus.in_data + ONE) : bus.in_data;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, bin_d} = shifted;
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = ST_HOLD;
                    out_bcd_d = shifted[BW+WIDTH-1 -: BW];
                    out_neg_d = neg_q;
                    ndig_d    = sig_digits(shifted[BW+WIDTH-1 -: BW]);
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            out_bcd_q <= '0;
            out_neg_q <= 1'b0;
            ndig_q    <= NDW'(1);
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            out_bcd_q <= out_bcd_d;
            out_neg_q <= out_neg_d;
            ndig_q    <= ndig_d;
        end
    end

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.out_valid   = (state_q == ST_HOLD);
    assign bus.out_bcd     = out_bcd_q;
    assign bus.out_neg     = out_neg_q;
    assign bus.out_ndigits = ndig_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_accum_bcd_converter.sv
// Bench: signed and unsigned converters run in lockstep on the same stream and
// are checked every cycle against an arithmetic model, plus literal results.
module tb_accum_bcd_converter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b1;
    logic        busy_s, busy_u;
    logic        chk_en = 1'b0;
    logic        rnd_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    accum_bcd_converter_if #(.WIDTH(32), .DIGITS(10)) bus_s ();
    accum_bcd_converter_if #(.WIDTH(32), .DIGITS(10)) bus_u ();

    assign bus_s.in_valid  = in_valid;
    assign bus_s.in_data   = in_data;
    assign bus_s.out_ready = out_ready;
    assign bus_u.in_valid  = in_valid;
    assign bus_u.in_data   = in_data;
    assign bus_u.out_ready = out_ready;

    accum_bcd_converter #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b1)) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave),
        .busy  (busy_s)
    );

    accum_bcd_converter #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b0)) u_dut_u (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_u.slave),
        .busy  (busy_u)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [39:0] to_bcd(input longint unsigned v);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int count_digits(input longint unsigned v);
        int n;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    int          m_st;       // 0 idle, 1 converting, 2 result held
    int          m_cnt;
    int          m_accepts = 0;
    int          m_txn = 0;
    logic [31:0] m_data;
    logic [39:0] m_bcd_s, m_bcd_u;
    logic        m_neg_s;
    int          m_nd_s, m_nd_u;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st    <= 0;
            m_cnt   <= 0;
            m_bcd_s <= '0;
            m_bcd_u <= '0;
            m_neg_s <= 1'b0;
            m_nd_s  <= 1;
            m_nd_u  <= 1;
        end else begin
            case (m_st)
                0: if (in_valid) begin
                    m_st      <= 1;
                    m_cnt     <= 0;
                    m_data    <= in_data;
                    m_accepts <= m_accepts + 1;
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt + 1 == 32) begin
                        longint unsigned mag;
                        mag = m_data[31] ? (64'h1_0000_0000 - longint'(m_data)) : longint'(m_data);
                        m_st    <= 2;
                        m_bcd_s <= to_bcd(mag);
                        m_neg_s <= m_data[31];
                        m_nd_s  <= count_digits(mag);
                        m_bcd_u <= to_bcd(longint'(m_data));
                        m_nd_u  <= count_digits(longint'(m_data));
                        m_txn   <= m_txn + 1;
                        $display("txn %0d in=%h signed: bcd=%h neg=%0d nd=%0d unsigned: bcd=%h nd=%0d",
                                 m_txn, m_data, to_bcd(mag), m_data[31], count_digits(mag),
                                 to_bcd(longint'(m_data)), count_digits(longint'(m_data)));
                    end
                end
                default: if (out_ready) m_st <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("s_in_ready",  bus_s.in_ready,  m_st == 0);
            check("s_out_valid", bus_s.out_valid, m_st == 2);
            check("s_busy",      busy_s,          m_st != 0);
            check("s_out_bcd",   bus_s.out_bcd,   m_bcd_s);
            check("s_out_neg",   bus_s.out_neg,   m_neg_s);
            check("s_ndigits",   bus_s.out_ndigits, m_nd_s);
            check("u_in_ready",  bus_u.in_ready,  m_st == 0);
            check("u_out_valid", bus_u.out_valid, m_st == 2);
            check("u_busy",      busy_u,          m_st != 0);
            check("u_out_bcd",   bus_u.out_bcd,   m_bcd_u);
            check("u_out_neg",   bus_u.out_neg,   0);
            check("u_ndigits",   bus_u.out_ndigits, m_nd_u);
        end
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] d);
        int prev, tries;
        prev = m_accepts;
        tries = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(posedge clk); #1;
            tries++;
        end while (m_accepts == prev && tries < 200);
        in_valid = 1'b0;
        if (m_accepts == prev) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus_s.out_valid && lat < 100);
    endtask

    task automatic convert(input logic [31:0] d,
                           input logic [39:0] e_bcd_s, input logic e_neg_s, input int e_nd_s,
                           input logic [39:0] e_bcd_u, input int e_nd_u);
        int lat;
        send(d);
        wait_valid(lat);
        check("latency",       lat, 32);
        check("lit_s_bcd",     bus_s.out_bcd, e_bcd_s);
        check("lit_s_neg",     bus_s.out_neg, e_neg_s);
        check("lit_s_ndigits", bus_s.out_ndigits, e_nd_s);
        check("lit_u_bcd",     bus_u.out_bcd, e_bcd_u);
        check("lit_u_neg",     bus_u.out_neg, 0);
        check("lit_u_ndigits", bus_u.out_ndigits, e_nd_u);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, guard;
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #1 check("rst_out_bcd", bus_s.out_bcd, 0);
        check("rst_ndigits", bus_s.out_ndigits, 1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", bus_s.in_ready, 1);

        convert(32'd0,        40'h0,          1'b0, 1,  40'h0,          1);
        convert(32'd12345,    40'h0000012345, 1'b0, 5,  40'h0000012345, 5);
        convert(32'hFFFFFFFF, 40'h1,          1'b1, 1,  40'h4294967295, 10);
        convert(32'h80000000, 40'h2147483648, 1'b1, 10, 40'h2147483648, 10);

        // backpressure with a stray request while the result is held
        out_ready = 1'b0;
        send(32'd777);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 1);
            in_data  = 32'd999;
            check("bp_bcd",      bus_s.out_bcd, 40'h777);
            check("bp_ndigits",  bus_s.out_ndigits, 3);
            check("bp_valid",    bus_s.out_valid, 1);
            check("bp_in_ready", bus_s.in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", bus_s.out_valid, 0);
        check("bp_release_ready", bus_s.in_ready, 1);
        convert(32'd999, 40'h999, 1'b0, 3, 40'h999, 3);

        // reset in the middle of a conversion
        send(32'd54321);
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", bus_s.out_valid, 0);
        check("arst_busy",  busy_s, 0);
        check("arst_bcd",   bus_s.out_bcd, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("arst_in_ready", bus_s.in_ready, 1);
        convert(32'd54321, 40'h54321, 1'b0, 5, 40'h54321, 5);

        // randomized traffic with random backpressure
        rnd_ready = 1'b1;
        for (int t = 0; t < 250; t++) begin
            logic [31:0] d;
            case ($urandom_range(0, 4))
                0: d = $urandom_range(0, 99999);
                1: d = 32'h0 - 32'($urandom_range(1, 99999));
                2: case ($urandom_range(0, 3))
                       0: d = 32'h80000000;
                       1: d = 32'h7FFFFFFF;
                       2: d = 32'hFFFFFFFF;
                       default: d = 32'h0;
                   endcase
                default: d = $urandom;
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 send(d);
        end
        guard = 0;
        while (m_st != 0 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        rnd_ready = 1'b0;
        check("drain_timeout", m_st, 0);
        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
